// File: rtl/regfile_host_ctrl.sv
// Host access sequencer for the CPU register file: shares the write port with
// CPU writeback (CPU first, starvation guard for the host) and forwards probe reads.
module regfile_host_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wena,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rf_wena,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_probe_addr,
  input  logic [DATA_W-1:0] rf_probe_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_busy,
  output logic              cpu_stall
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_WR = 3'd1,
    FORCE   = 3'd2,
    RD      = 3'd3,
    ACK     = 3'd4
  } state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        starve_cnt_q;
  logic [7:0]        starve_cnt_d;
  logic              host_ack_q;
  logic              host_busy_q;
  logic              cpu_stall_q;
  logic [DATA_W-1:0] rdata_q;
  logic              host_grant;
  logic              fwd_hit;

  // The host only owns the write port in a cycle the CPU leaves idle.
  assign host_grant = we_q && !cpu_wena && (state_q == WAIT_WR || state_q == FORCE);
  assign fwd_hit    = cpu_wena && (cpu_waddr == addr_q);
  assign starve_cnt_d = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;

  always_comb begin
    rf_wena  = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (cpu_wena) begin
      rf_wena  = 1'b1;
      rf_waddr = cpu_waddr;
      rf_wdata = cpu_wdata;
    end else if (host_grant) begin
      rf_wena  = 1'b1;
      rf_waddr = addr_q;
      rf_wdata = wdata_q;
    end
  end

  assign rf_probe_addr = (state_q == RD) ? addr_q : '0;

  assign host_ack   = host_ack_q;
  assign host_busy  = host_busy_q;
  assign cpu_stall  = cpu_stall_q;
  assign host_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      host_ack_q   <= 1'b0;
      host_busy_q  <= 1'b0;
      cpu_stall_q  <= 1'b0;
      rdata_q      <= '0;
    end else begin
      host_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_req) begin
            we_q         <= host_we;
            addr_q       <= host_addr;
            wdata_q      <= host_wdata;
            starve_cnt_q <= '0;
            host_busy_q  <= 1'b1;
            state_q      <= host_we ? WAIT_WR : RD;
          end
        end
        WAIT_WR: begin
          if (host_grant) begin
            starve_cnt_q <= '0;
            host_ack_q   <= 1'b1;
            state_q      <= ACK;
          end else begin
            starve_cnt_q <= starve_cnt_d;
            if (starve_cnt_d == LIMIT) begin
              cpu_stall_q <= 1'b1;
              state_q     <= FORCE;
            end
          end
        end
        FORCE: begin
          // Stall only stops new writebacks; in-flight ones still win the port.
          if (host_grant) begin
            starve_cnt_q <= '0;
            cpu_stall_q  <= 1'b0;
            host_ack_q   <= 1'b1;
            state_q      <= ACK;
          end
        end
        RD: begin
          rdata_q    <= fwd_hit ? cpu_wdata : rf_probe_data;
          host_ack_q <= 1'b1;
          state_q    <= ACK;
        end
        ACK: begin
          host_busy_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          host_busy_q <= 1'b0;
          cpu_stall_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_host_ctrl.sv
// Directed bench for regfile_host_ctrl with a behavioural 16x32 register file
// on the write and probe ports.
module tb_regfile_host_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_wena;
  logic [3:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        rf_wena;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_probe_addr;
  logic [31:0] rf_probe_data;
  logic        host_req;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_busy;
  logic        cpu_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] rf_mem [16];

  regfile_host_ctrl #(.ADDR_W(4), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_wena      (cpu_wena),
    .cpu_waddr     (cpu_waddr),
    .cpu_wdata     (cpu_wdata),
    .rf_wena       (rf_wena),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_probe_addr (rf_probe_addr),
    .rf_probe_data (rf_probe_data),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_ack      (host_ack),
    .host_rdata    (host_rdata),
    .host_busy     (host_busy),
    .cpu_stall     (cpu_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model
  initial for (int i = 0; i < 16; i++) rf_mem[i] = 32'h0;
  always @(posedge clk) if (rf_wena) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_probe_data = rf_mem[rf_probe_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to 2 time units after the next rising edge
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic host_cmd(input logic we, input logic [3:0] a, input logic [31:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    host_cmd(1'b1, a, d);
    tick;
    host_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    host_cmd(1'b0, a, 32'h0);
    tick;
    host_req = 1'b0;
    tick;
    #1;
    check({tag, "_ack"}, host_ack, 1);
    check({tag, "_data"}, host_rdata, exp);
    tick;
  endtask

  int ack_cnt;

  initial begin
    rst = 1'b1; cpu_wena = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // reset state
    #3;
    check("rst_ack", host_ack, 0);
    check("rst_busy", host_busy, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_rdata", host_rdata, 0);
    cpu_wena = 1'b1; cpu_waddr = 4'd2; cpu_wdata = 32'h0000_0077;
    #1;
    check("rst_rf_wena_cpu", rf_wena, 1);
    check("rst_rf_waddr_cpu", rf_waddr, 2);
    cpu_wena = 1'b0;
    #1;
    check("rst_rf_wena_idle", rf_wena, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    tick;

    // unblocked write r3, then read back
    host_cmd(1'b1, 4'd3, 32'hDEAD_BEEF);
    #1;
    check("uw_c0_rf_wena", rf_wena, 0);
    tick;
    host_req = 1'b0;
    #1;
    check("uw_c1_rf_wena", rf_wena, 1);
    check("uw_c1_rf_waddr", rf_waddr, 3);
    check("uw_c1_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("uw_c1_busy", host_busy, 1);
    check("uw_c1_ack", host_ack, 0);
    tick;
    #1;
    check("uw_c2_ack", host_ack, 1);
    check("uw_c2_rf_wena", rf_wena, 0);
    tick;
    #1;
    check("uw_c3_ack", host_ack, 0);
    check("uw_c3_busy", host_busy, 0);
    host_cmd(1'b0, 4'd3, 32'h0);
    tick;
    host_req = 1'b0;
    #1;
    check("rd3_probe_addr", rf_probe_addr, 3);
    check("rd3_c1_ack", host_ack, 0);
    tick;
    #1;
    check("rd3_ack", host_ack, 1);
    check("rd3_data", host_rdata, 32'hDEAD_BEEF);
    check("rd3_probe_idle", rf_probe_addr, 0);
    tick;
    #1;
    check("rd3_ack_gone", host_ack, 0);
    check("rd3_data_held", host_rdata, 32'hDEAD_BEEF);

    do_write(4'd1, 32'hCAFE_F00D);

    // blocked write r5: three CPU writebacks first
    host_cmd(1'b1, 4'd5, 32'h0000_0011);
    tick;
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_wena = 1'b1; cpu_waddr = 4'(8 + i); cpu_wdata = 32'hA0 + i;
      #1;
      check("bw_cpu_waddr", rf_waddr, 8 + i);
      check("bw_cpu_wdata", rf_wdata, 32'hA0 + i);
      check("bw_stall", cpu_stall, 0);
      tick;
    end
    cpu_wena = 1'b0;
    #1;
    check("bw_host_wena", rf_wena, 1);
    check("bw_host_waddr", rf_waddr, 5);
    check("bw_host_wdata", rf_wdata, 32'h11);
    check("bw_grant_ack", host_ack, 0);
    tick;
    #1;
    check("bw_ack", host_ack, 1);
    check("bw_ack_stall", cpu_stall, 0);
    tick;
    do_read(4'd5, 32'h11, "bw_rd5");
    do_read(4'd9, 32'hA1, "bw_rd9");

    // starvation: CPU writes every cycle from the cycle after accept
    host_cmd(1'b1, 4'd2, 32'h0000_0055);
    tick;
    host_req = 1'b0;
    cpu_wena = 1'b1; cpu_waddr = 4'd12; cpu_wdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      cpu_wdata = 32'(i);
      #1;
      check("sv_stall_low", cpu_stall, 0);
      check("sv_cpu_waddr", rf_waddr, 12);
      tick;
    end
    #1;
    check("sv_force_stall", cpu_stall, 1);
    check("sv_force_busy", host_busy, 1);
    check("sv_force_cnt", dut.starve_cnt_q, 8);
    check("sv_force_cpu_wins", rf_waddr, 12);
    tick;
    #1;
    check("sv_force2_stall", cpu_stall, 1);
    tick;
    cpu_wena = 1'b0;
    #1;
    check("sv_grant_wena", rf_wena, 1);
    check("sv_grant_waddr", rf_waddr, 2);
    check("sv_grant_wdata", rf_wdata, 32'h55);
    check("sv_grant_ack", host_ack, 0);
    tick;
    #1;
    check("sv_ack", host_ack, 1);
    check("sv_stall_drop", cpu_stall, 0);
    tick;
    do_read(4'd2, 32'h55, "sv_rd2");

    // forwarding on r7, then unrelated CPU write to r6
    do_write(4'd7, 32'h0000_0BAD);
    host_cmd(1'b0, 4'd7, 32'h0);
    tick;
    host_req = 1'b0;
    cpu_wena = 1'b1; cpu_waddr = 4'd7; cpu_wdata = 32'h0000_1234;
    tick;
    cpu_wena = 1'b0;
    #1;
    check("fw_ack", host_ack, 1);
    check("fw_data", host_rdata, 32'h1234);
    tick;
    host_cmd(1'b0, 4'd7, 32'h0);
    tick;
    host_req = 1'b0;
    cpu_wena = 1'b1; cpu_waddr = 4'd6; cpu_wdata = 32'h0000_5678;
    tick;
    cpu_wena = 1'b0;
    #1;
    check("nf_ack", host_ack, 1);
    check("nf_data", host_rdata, 32'h1234);
    tick;

    // requests during busy states are ignored
    ack_cnt = 0;
    host_cmd(1'b1, 4'd4, 32'h0000_0044);
    tick;
    host_cmd(1'b0, 4'd4, 32'h0);
    #1;
    check("bz_wait_busy", host_busy, 1);
    if (host_ack) ack_cnt++;
    tick;
    #1;
    if (host_ack) ack_cnt++;
    check("bz_ack_state", host_ack, 1);
    tick;
    #1;
    if (host_ack) ack_cnt++;
    check("bz_idle_busy", host_busy, 0);
    check("bz_single_ack", ack_cnt, 1);
    tick;
    host_req = 1'b0;
    #1;
    check("bz_accept_busy", host_busy, 1);
    check("bz_rd_ack", host_ack, 0);
    tick;
    #1;
    check("bz_rd_ack2", host_ack, 1);
    check("bz_rd_data", host_rdata, 32'h44);
    tick;

    // reset while in FORCE drops the host write to r1
    host_cmd(1'b1, 4'd1, 32'hBEEF_0000);
    tick;
    host_req = 1'b0;
    cpu_wena = 1'b1; cpu_waddr = 4'd13; cpu_wdata = 32'h1;
    repeat (8) tick;
    #1;
    check("rf_pre_stall", cpu_stall, 1);
    cpu_wena = 1'b0;
    rst = 1'b1;
    #1;
    check("rf_stall_clr", cpu_stall, 0);
    check("rf_busy_clr", host_busy, 0);
    check("rf_cnt_clr", dut.starve_cnt_q, 0);
    check("rf_no_host_wr", rf_wena, 0);
    tick;
    rst = 1'b0;
    tick;
    do_read(4'd1, 32'hCAFE_F00D, "rf_rd1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
